// File: rtl/act_interp_pipe.sv
// Three-stage activation pipeline: piecewise-linear LUT interpolation, ReLU or identity,
// with a writable LUT and a single global advance enable for backpressure.
module act_interp_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     lut_wr_en,
  input  logic [ADDR_W-1:0]        lut_wr_addr,
  input  logic signed [DATA_W-1:0] lut_wr_data
);

  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PROD_W = DATA_W + FRAC_W + 2;
  localparam logic [ADDR_W-1:0]        TOP_ADDR = ADDR_W'((1 << (ADDR_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = PROD_W'(-(1 << (DATA_W - 1)));

  logic                     adv;
  logic                     s1_valid, s2_valid;
  logic signed [DATA_W-1:0] s1_z, s2_z;
  logic [1:0]               s1_mode, s2_mode;
  logic signed [DATA_W-1:0] s2_base, s2_next;
  logic [FRAC_W-1:0]        s2_rem;

  logic signed [DATA_W-1:0] lut [DEPTH];
  logic [ADDR_W-1:0]        rd_addr, nxt_addr;
  logic signed [DATA_W-1:0] rd_base, rd_next;

  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] prod, shifted, interp;
  logic signed [DATA_W-1:0] result;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // The most-positive segment has no upper neighbour, so it holds flat instead of wrapping.
  assign rd_addr  = s1_z[DATA_W-1:FRAC_W];
  assign nxt_addr = rd_addr + ADDR_W'(1);
  assign rd_base  = lut[rd_addr];
  assign rd_next  = (rd_addr == TOP_ADDR) ? rd_base : lut[nxt_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) lut[i] <= '0;
    end else if (lut_wr_en) begin
      lut[lut_wr_addr] <= lut_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_z      <= '0;
      s1_mode   <= '0;
      s2_valid  <= 1'b0;
      s2_z      <= '0;
      s2_mode   <= '0;
      s2_base   <= '0;
      s2_next   <= '0;
      s2_rem    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_z      <= in_data;
      s1_mode   <= in_mode;
      s2_valid  <= s1_valid;
      s2_z      <= s1_z;
      s2_mode   <= s1_mode;
      s2_base   <= rd_base;
      s2_next   <= rd_next;
      s2_rem    <= s1_z[FRAC_W-1:0];
      out_valid <= s2_valid;
      out_data  <= result;
    end
  end

  // The shift is kept in its own all-signed assignment so it stays arithmetic (floor).
  always_comb begin
    diff    = {s2_next[DATA_W-1], s2_next} - {s2_base[DATA_W-1], s2_base};
    prod    = $signed({{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff})
            * $signed({{(PROD_W-FRAC_W){1'b0}}, s2_rem});
    shifted = prod >>> FRAC_W;
    interp  = shifted + $signed({{(PROD_W-DATA_W){s2_base[DATA_W-1]}}, s2_base});
    result  = s2_z;
    case (s2_mode)
      2'd0: begin
        if (interp > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
        else if (interp < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
        else                       result = interp[DATA_W-1:0];
      end
      2'd1:    result = (s2_z > 0) ? s2_z : '0;
      default: result = s2_z;
    endcase
  end

endmodule

// File: tb/tb_act_interp_pipe.sv
// Scoreboard bench for act_interp_pipe: directed vectors push expected results, a negedge
// monitor pops and compares them, and also watches backpressure and reset behaviour.
module tb_act_interp_pipe;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic              lut_wr_en;
  logic [3:0]        lut_wr_addr;
  logic signed [7:0] lut_wr_data;

  typedef struct {
    logic signed [7:0] val;
    int                acc_cyc;
    bit                chk_lat;
  } exp_t;

  exp_t              exp_q[$];
  int                errors = 0;
  int                checks = 0;
  int                cyc = 0;
  bit                stall_active = 1'b0;
  logic signed [7:0] held_data;

  act_interp_pipe #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents one sample, waits (bounded) for in_ready, and records the expected result.
  task automatic apply_stimulus(input logic [7:0] d, input logic [1:0] m,
                                input logic signed [7:0] exp, input bit push, input bit lat);
    exp_t e;
    int   waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 20) begin
        check_output("in_ready_timeout", 0, 1);
        break;
      end
    end
    if (push) begin
      e.val = exp; e.acc_cyc = cyc; e.chk_lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic lut_write(input logic [3:0] a, input logic signed [7:0] d);
    lut_wr_en = 1'b1; lut_wr_addr = a; lut_wr_data = d;
    @(posedge clk); #1;
    lut_wr_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_output("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: pops on each transfer; during a stall, checks held data and in_ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        stall_active <= 1'b0;
        if (exp_q.size() == 0) begin
          check_output("unexpected_output", int'(out_data), 9999);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("out_data", int'(out_data), int'(e.val));
          if (e.chk_lat) check_output("latency", cyc - e.acc_cyc, 3);
        end
      end else if (out_valid && !out_ready) begin
        check_output("in_ready_during_stall", int'(in_ready), 0);
        if (stall_active) check_output("held_out_data", int'(out_data), int'(held_data));
        held_data    <= out_data;
        stall_active <= 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    lut_wr_en = 1'b0; lut_wr_addr = '0; lut_wr_data = '0;
    #2;
    check_output("reset_out_valid", int'(out_valid), 0);
    check_output("reset_out_data", int'(out_data), 0);
    check_output("reset_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    lut_write(4'd2, 8'sd16);
    lut_write(4'd3, 8'sd32);
    lut_write(4'd7, 8'sd100);
    lut_write(4'd15, -8'sd8);
    lut_write(4'd0, 8'sd0);
    lut_write(4'd4, 8'sd10);
    lut_write(4'd5, 8'sd7);

    $display("[TB] interpolation with 3-cycle latency");
    apply_stimulus(8'h28, 2'd0, 8'sd24, 1'b1, 1'b1);
    drain();

    $display("[TB] LUT write colliding with a read");
    apply_stimulus(8'h20, 2'd0, 8'sd16, 1'b1, 1'b1);
    lut_wr_en = 1'b1; lut_wr_addr = 4'd2; lut_wr_data = 8'sd50;
    apply_stimulus(8'h20, 2'd0, 8'sd50, 1'b1, 1'b1);
    lut_wr_en = 1'b0;
    drain();

    $display("[TB] segment boundaries and negative slope");
    apply_stimulus(8'h7F, 2'd0, 8'sd100, 1'b1, 1'b1);
    apply_stimulus(8'hF8, 2'd0, -8'sd4, 1'b1, 1'b1);
    apply_stimulus(8'h41, 2'd0, 8'sd9, 1'b1, 1'b1);
    drain();

    $display("[TB] ReLU and identity modes back-to-back");
    apply_stimulus(8'hFB, 2'd1, 8'sd0, 1'b1, 1'b1);
    apply_stimulus(8'h14, 2'd1, 8'sd20, 1'b1, 1'b1);
    apply_stimulus(8'h00, 2'd1, 8'sd0, 1'b1, 1'b1);
    apply_stimulus(8'h80, 2'd1, 8'sd0, 1'b1, 1'b1);
    apply_stimulus(8'h80, 2'd2, -8'sd128, 1'b1, 1'b1);
    apply_stimulus(8'h05, 2'd3, 8'sd5, 1'b1, 1'b1);
    drain();

    $display("[TB] backpressure mid-stream");
    fork
      begin
        for (int i = 1; i <= 6; i++) apply_stimulus(8'(i * 3), 2'd2, 8'(i * 3), 1'b1, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] reset with samples in flight");
    apply_stimulus(8'h11, 2'd2, 8'sd0, 1'b0, 1'b0);
    apply_stimulus(8'h22, 2'd2, 8'sd0, 1'b0, 1'b0);
    apply_stimulus(8'h33, 2'd2, 8'sd0, 1'b0, 1'b0);
    check_output("pre_reset_out_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    check_output("flush_out_valid", int'(out_valid), 0);
    check_output("flush_out_data", int'(out_data), 0);
    check_output("flush_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    apply_stimulus(8'h28, 2'd0, 8'sd0, 1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/act_interp_pipe.md
ACT_INTERP_PIPE -- requirements
Module: act_interp_pipe

Interface
REQ-001 Parameter DATA_W, default 8, signed width of the activation input and output samples.
REQ-002 Parameter ADDR_W, default 4, number of upper input bits used as the LUT address, giving 2^ADDR_W entries; FRAC_W = DATA_W-ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_data and in_mode are valid this cycle.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 in_data  input  DATA_W  signed pre-activation value z.
REQ-008 in_mode  input  2  per-sample mode: 0 LUT interpolation, 1 ReLU, 2 identity, 3 reserved (treated as identity).
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 out_data  output  DATA_W  signed activation result.
REQ-012 lut_wr_en  input  1  LUT write strobe.
REQ-013 lut_wr_addr  input  ADDR_W  LUT entry to write.
REQ-014 lut_wr_data  input  DATA_W  signed value written to the entry.

Function
REQ-015 Three-stage pipeline: S1 input register (z, mode), S2 LUT read register (base, next, remaining, mode, z), S3 output register.
REQ-016 Global advance enable adv = !out_valid || out_ready; in_ready = adv; every stage register loads only when adv=1.
REQ-017 A sample is accepted when in_valid && in_ready; with no stall, out_valid rises exactly 3 cycles after acceptance; full throughput of 1 sample/cycle.
REQ-018 Per-stage valid bits propagate with adv; bubbles (invalid slots) advance like data and are not compressed.
REQ-019 While out_valid && !out_ready, out_data and all stage registers hold unchanged.
REQ-020 Address = z[DATA_W-1:FRAC_W] interpreted as unsigned bits; remaining = z[FRAC_W-1:0] unsigned.
REQ-021 base = LUT[address]; next = LUT[address+1 mod 2^ADDR_W], except when address = 2^(ADDR_W-1)-1 (most-positive segment), where next = base.
REQ-022 Address all-ones wraps to entry 0 for next (segment spanning -1..0 interpolates toward LUT[0]).
REQ-023 Mode 0 result = base + floor(((next-base) * remaining) / 2^FRAC_W), with the difference computed at DATA_W+1 bits, the product at DATA_W+FRAC_W+2 bits signed, and the shift arithmetic.
REQ-024 Mode 0 result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-025 Mode 1 result = z if z > 0 else 0; mode 2/3 result = z; LUT not consulted.
REQ-026 LUT is a register array of 2^ADDR_W signed DATA_W entries; a write updates the entry at the clock edge where lut_wr_en=1, independent of adv.
REQ-027 An S2 read in the same cycle as a write to that entry returns the old value; reads in later cycles return the new value.
REQ-028 Simultaneous writes and streaming are legal; no stall is generated by writes.

Reset
REQ-029 rst=1 clears all stage valid bits immediately: out_valid=0, out_data=0, in_ready=1.
REQ-030 rst=1 clears every LUT entry to 0.
REQ-031 Samples in flight when rst asserts are discarded and never presented at the output.
REQ-032 First sample accepted after rst deasserts follows REQ-017 timing.

Verification (DATA_W=8, ADDR_W=4)
REQ-033 LUT[2]=16, LUT[3]=32; mode 0, in_data=0x28 -> out_data=24, 3 cycles after acceptance.
REQ-034 LUT[7]=100; mode 0, in_data=0x7F -> 100 (no interpolation into negative segment); LUT[15]=-8, LUT[0]=0, in_data=0xF8 -> -4.
REQ-035 LUT[4]=10, LUT[5]=7; mode 0, in_data=0x41 -> 9 (floor of -3/16 = -1).
REQ-036 Mode 1 stream -5, 20, 0 -> 0, 20, 0 back-to-back on consecutive cycles; mode 2 input -128 -> -128.
REQ-037 Stream 6 samples with out_ready low for 4 cycles mid-stream -> in_ready low while out_valid held, out_data stable, all 6 results in order, none lost or duplicated.
REQ-038 Assert rst with 3 samples in flight and LUT loaded -> out_valid=0 immediately, no stale output afterwards, LUT reads 0 for a subsequent mode-0 sample (result 0).
